// File: rtl/nuc970_parity_collect_if.sv
// Beat bus between the BCH encoder output and the parity collector.
// master: the encoder side (drives beats); slave: the collector.
//
// Handshake: there is no ready. A beat is presented on data_in with its
// tags (first/last/data_bits/ecc_bits) and is accepted on any rising edge
// where ce=1; cycles with ce=0 carry no beat. Outputs use plain valid
// pulses (dout_valid, ecc_valid) with no backpressure from downstream.
interface nuc970_parity_collect_if #(
  parameter int BITS  = 8,
  parameter int ECC_W = 64
);
  logic             ce;
  logic [BITS-1:0]  data_in;
  logic             first;
  logic             last;
  logic             data_bits;
  logic             ecc_bits;
  logic             err_clr;
  logic [BITS-1:0]  dout;
  logic             dout_valid;
  logic             dout_first;
  logic             dout_last;
  logic [ECC_W-1:0] ecc_out;
  logic             ecc_valid;
  logic             protocol_err;

  modport master (
    output ce, data_in, first, last, data_bits, ecc_bits, err_clr,
    input  dout, dout_valid, dout_first, dout_last, ecc_out, ecc_valid,
           protocol_err
  );

  modport slave (
    input  ce, data_in, first, last, data_bits, ecc_bits, err_clr,
    output dout, dout_valid, dout_first, dout_last, ecc_out, ecc_valid,
           protocol_err
  );
endinterface

// File: rtl/nuc970_parity_collect.sv
// NUC970 BCH parity collector: forwards data beats with one register stage
// and packs the trailing ECC beats into one parity word per codeword.
// Optional feature macro: NUC970_PARITY_INVERT_EN (store inverted parity so
// a blank page reads as all-ones parity; pad bits stay 1 either way).
// state_dbg exposes the frame FSM state for checkers.
module nuc970_parity_collect #(
  parameter int T         = 4,
  parameter int DATA_BITS = 4288,
  parameter int BITS      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  nuc970_parity_collect_if.slave       bus,
  output logic [1:0]                   state_dbg
);
  localparam int ECC_BITS   = T * 15;
  localparam int DATA_BEATS = DATA_BITS / BITS;
  localparam int ECC_BEATS  = (ECC_BITS + BITS - 1) / BITS;
  localparam int ECC_W      = ECC_BEATS * BITS;
  localparam int PAD        = ECC_W - ECC_BITS;
  localparam int DCNT_W     = $clog2(DATA_BEATS + 1);
  localparam int ECNT_W     = $clog2(ECC_BEATS + 1);
  localparam logic [ECC_W-1:0] PAD_MASK = ECC_W'((64'd1 << PAD) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ECC  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [DCNT_W-1:0] dcnt;
  logic [ECNT_W-1:0] ecnt;
  logic [ECC_W-1:0]  sr;
  logic [ECC_W-1:0]  asm_word;
  logic [ECC_W-1:0]  load_word;

  logic err_ev;    // framing error seen on this beat
  logic fwd;       // beat goes out on dout
  logic restart;   // beat is data beat 0 of a new frame
  logic fwd_last;  // forwarded beat is the final data beat
  logic shift;     // non-final ECC beat enters the shift register
  logic done;      // final ECC beat with last: publish parity

  assign state_dbg = state;

  // The final beat completes the word without first passing through sr.
  assign asm_word = {sr[ECC_W-BITS-1:0], bus.data_in};
`ifdef NUC970_PARITY_INVERT_EN
  assign load_word = ~asm_word | PAD_MASK;
`else
  assign load_word = asm_word | PAD_MASK;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and beat classification; only qualified beats have effect.
  always_comb begin
    state_d  = state;
    err_ev   = 1'b0;
    fwd      = 1'b0;
    restart  = 1'b0;
    shift    = 1'b0;
    done     = 1'b0;
    fwd_last = 1'b0;
    if (bus.ce) begin
      if (bus.data_bits && bus.ecc_bits) begin
        err_ev  = 1'b1;
        state_d = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.first && bus.data_bits) begin
              restart = 1'b1;
              fwd     = 1'b1;
              state_d = DATA;
            end else if (bus.ecc_bits) begin
              err_ev = 1'b1;
            end
          end
          DATA, ECC: begin
            if (bus.first) begin
              // A new frame overrides the one in flight.
              err_ev = 1'b1;
              if (bus.data_bits) begin
                restart = 1'b1;
                fwd     = 1'b1;
                state_d = DATA;
              end else begin
                state_d = IDLE;
              end
            end else if (state == DATA) begin
              if (bus.ecc_bits || (bus.data_bits && bus.last)) begin
                err_ev  = 1'b1;
                state_d = IDLE;
              end else if (bus.data_bits) begin
                fwd      = 1'b1;
                fwd_last = (dcnt == DCNT_W'(DATA_BEATS - 1));
                if (fwd_last) state_d = ECC;
              end
            end else begin
              if (bus.data_bits) begin
                err_ev  = 1'b1;
                state_d = IDLE;
              end else if (bus.ecc_bits) begin
                if (ecnt == ECNT_W'(ECC_BEATS - 1)) begin
                  if (bus.last) done = 1'b1;
                  else          err_ev = 1'b1;
                  state_d = IDLE;
                end else if (bus.last) begin
                  err_ev  = 1'b1;
                  state_d = IDLE;
                end else begin
                  shift = 1'b1;
                end
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Beat counters and parity shift register; both restart at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= '0;
      ecnt <= '0;
      sr   <= '0;
    end else begin
      if (restart)  dcnt <= DCNT_W'(1);
      else if (fwd) dcnt <= dcnt + DCNT_W'(1);
      if (restart)    ecnt <= '0;
      else if (shift) ecnt <= ecnt + ECNT_W'(1);
      if (shift) sr <= {sr[ECC_W-BITS-1:0], bus.data_in};
    end
  end

  // Data forwarding stage; valid and its tags drop whenever no beat is forwarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_first <= 1'b0;
      bus.dout_last  <= 1'b0;
    end else begin
      bus.dout_valid <= fwd;
      bus.dout_first <= restart;
      bus.dout_last  <= fwd_last;
      if (fwd) bus.dout <= bus.data_in;
    end
  end

  // Parity publish (one-cycle pulse) and sticky error flag; an error beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ecc_out      <= '0;
      bus.ecc_valid    <= 1'b0;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.ecc_valid <= done;
      if (done) bus.ecc_out <= load_word;
      if (err_ev)           bus.protocol_err <= 1'b1;
      else if (bus.err_clr) bus.protocol_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nuc970_parity_collect.sv
// Bench for nuc970_parity_collect: table of frame scenarios plus hand-written
// sequences for idle-state errors, err_clr priority and mid-frame reset.
module tb_nuc970_parity_collect;
  localparam int DATA_BEATS = 536;
  localparam int ECC_BEATS  = 8;
`ifdef NUC970_PARITY_INVERT_EN
  localparam logic [63:0] PLAN_WORD = 64'hEDCBA9876543211F;
`else
  localparam logic [63:0] PLAN_WORD = 64'h123456789ABCDEEF;
`endif

  typedef struct {
    bit ce_toggle;
    int kind;       // 0 good, 1 ecc in DATA, 2 early last, 3 missing last,
                    // 4 data in ECC, 5 first in DATA, 6 both type bits
    int pos;
    bit plan_ecc;
    bit exp_err;
    bit exp_valid;
    bit clr_after;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;
  int         dv_count;
  bit         ce_toggle;
  logic [63:0] last_good;
  logic [9:0]  data_exp_q[$];
  logic [63:0] ecc_exp_q[$];
  vec_t        vecs[10];

  nuc970_parity_collect_if bif ();

  nuc970_parity_collect dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ecc_model(input logic [7:0] b[8]);
    logic [63:0] w;
    w = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
`ifdef NUC970_PARITY_INVERT_EN
    w = ~w;
`endif
    w[3:0] = 4'hF;
    return w;
  endfunction

  // Scoreboard: compare DUT output beats and parity pulses against queues.
  always @(negedge clk) begin
    if (bif.dout_valid) begin
      dv_count++;
      if (data_exp_q.size() == 0) begin
        check("dout_unexpected", 64'({bif.dout_first, bif.dout_last, bif.dout}), 64'hDEAD);
      end else begin
        check("dout_beat", 64'({bif.dout_first, bif.dout_last, bif.dout}), 64'(data_exp_q.pop_front()));
      end
    end
    if (bif.ecc_valid) begin
      if (ecc_exp_q.size() == 0) begin
        check("ecc_unexpected", bif.ecc_out, ~bif.ecc_out);
      end else begin
        check("ecc_out", bif.ecc_out, ecc_exp_q.pop_front());
      end
    end
  end

  // Driver tasks.
  task automatic idle_inputs();
    bif.ce = 1'b0; bif.data_in = '0; bif.first = 1'b0; bif.last = 1'b0;
    bif.data_bits = 1'b0; bif.ecc_bits = 1'b0; bif.err_clr = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic f, input logic l,
                           input logic db, input logic eb);
    bif.ce = 1'b1; bif.data_in = d; bif.first = f; bif.last = l;
    bif.data_bits = db; bif.ecc_bits = eb;
    @(posedge clk); #1;
    idle_inputs();
    if (ce_toggle) begin
      // Junk on the bus while ce=0 must be ignored.
      bif.data_in = 8'($urandom_range(0, 255));
      bif.first = 1'($urandom_range(0, 1));
      bif.last = 1'($urandom_range(0, 1));
      bif.data_bits = 1'($urandom_range(0, 1));
      bif.ecc_bits = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic send_data(input int i, input logic f);
    data_exp_q.push_back({f, (i == DATA_BEATS - 1) ? 1'b1 : 1'b0, 8'(i)});
    send_beat(8'(i), f, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] ecc[8];
    logic [7:0] plan[8];
    bit aborted;
    logic lst;
    int exp_fwd;
    plan = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hE0};
    for (int j = 0; j < ECC_BEATS; j++)
      ecc[j] = v.plan_ecc ? plan[j] : 8'($urandom_range(0, 255));
    ce_toggle = v.ce_toggle;
    dv_count = 0;
    exp_fwd = 0;
    aborted = 0;
    if (v.kind == 5) begin
      for (int i = 0; i < v.pos; i++) begin
        send_data(i, (i == 0) ? 1'b1 : 1'b0);
        exp_fwd++;
      end
    end
    for (int i = 0; i < DATA_BEATS; i++) begin
      if (v.kind == 1 && i == v.pos) begin
        send_beat(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        aborted = 1;
        break;
      end
      if (v.kind == 6 && i == v.pos) begin
        send_beat(8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        aborted = 1;
        break;
      end
      send_data(i, (i == 0) ? 1'b1 : 1'b0);
      exp_fwd++;
    end
    if (v.exp_valid) ecc_exp_q.push_back(ecc_model(ecc));
    if (!aborted) begin
      for (int j = 0; j < ECC_BEATS; j++) begin
        if (v.kind == 4 && j == v.pos) begin
          send_beat(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
          break;
        end
        lst = (j == ECC_BEATS - 1);
        if (v.kind == 2 && j == v.pos) lst = 1'b1;
        if (v.kind == 3) lst = 1'b0;
        send_beat(ecc[j], 1'b0, lst, 1'b0, 1'b1);
        if (v.kind == 2 && j == v.pos) break;
      end
    end
    ce_toggle = 0;
    repeat (3) @(posedge clk);
    #1;
    if (v.exp_valid) last_good = ecc_model(ecc);
    check({tag, "_err"}, 64'(bif.protocol_err), 64'(v.exp_err));
    check({tag, "_state_idle"}, 64'(state_dbg), 64'(0));
    check({tag, "_dout_count"}, 64'(dv_count), 64'(exp_fwd));
    check({tag, "_data_q_left"}, 64'(data_exp_q.size()), 64'(0));
    check({tag, "_ecc_q_left"}, 64'(ecc_exp_q.size()), 64'(0));
    check({tag, "_ecc_hold"}, bif.ecc_out, last_good);
    if (v.plan_ecc && v.exp_valid) check({tag, "_plan_word"}, bif.ecc_out, PLAN_WORD);
    if (v.clr_after) begin
      bif.err_clr = 1'b1;
      @(posedge clk); #1;
      bif.err_clr = 1'b0;
      check({tag, "_err_cleared"}, 64'(bif.protocol_err), 64'(0));
    end
  endtask

  initial begin
    vec_t good;
    checks = 0;
    failures = 0;
    dv_count = 0;
    ce_toggle = 0;
    last_good = '0;
    vecs[0] = '{0, 0, 0,   1, 0, 1, 0};
    vecs[1] = '{1, 0, 0,   1, 0, 1, 0};
    vecs[2] = '{0, 1, 100, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 0,   1, 1, 1, 1};
    vecs[4] = '{0, 2, 4,   0, 1, 0, 1};
    vecs[5] = '{0, 3, 7,   0, 1, 0, 1};
    vecs[6] = '{0, 4, 2,   0, 1, 0, 1};
    vecs[7] = '{0, 5, 10,  0, 1, 1, 1};
    vecs[8] = '{0, 6, 50,  0, 1, 0, 1};
    vecs[9] = '{1, 0, 0,   0, 0, 1, 0};

    // Reset state.
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(bif.dout), 64'(0));
    check("rst_dout_flags", 64'({bif.dout_valid, bif.dout_first, bif.dout_last}), 64'(0));
    check("rst_ecc_out", bif.ecc_out, 64'(0));
    check("rst_ecc_valid", 64'(bif.ecc_valid), 64'(0));
    check("rst_err", 64'(bif.protocol_err), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // IDLE: data beat without first is ignored; ECC beat is an error.
    send_beat(8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("idle_data_ignored_err", 64'(bif.protocol_err), 64'(0));
    check("idle_data_ignored_state", 64'(state_dbg), 64'(0));
    send_beat(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_ecc_err", 64'(bif.protocol_err), 64'(1));
    // err_clr together with a new error: the error wins.
    bif.err_clr = 1'b1;
    send_beat(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_vs_err", 64'(bif.protocol_err), 64'(1));
    // err_clr acts without ce.
    bif.err_clr = 1'b1;
    @(posedge clk); #1;
    bif.err_clr = 1'b0;
    check("clr_no_ce", 64'(bif.protocol_err), 64'(0));

    // Table of frame scenarios.
    for (int k = 0; k < 10; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Reset while the frame is in its ECC phase.
    for (int i = 0; i < DATA_BEATS; i++) send_data(i, (i == 0) ? 1'b1 : 1'b0);
    send_beat(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_dout", 64'(bif.dout), 64'(0));
    check("midrst_flags", 64'({bif.dout_valid, bif.dout_first, bif.dout_last, bif.ecc_valid, bif.protocol_err}), 64'(0));
    check("midrst_ecc_out", bif.ecc_out, 64'(0));
    check("midrst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    last_good = '0;
    @(posedge clk); #1;
    good = '{0, 0, 0, 1, 0, 1, 0};
    run_frame(good, "after_rst");

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nuc970_parity_collect.md
# nuc970_parity_collect

Downstream stage of the NUC970 BCH encoder wrapper. Consumes the encoder's output beat stream (data beats followed by ECC beats), forwards data beats to the NAND write path with one register stage, and assembles the ECC beats into one packed parity word per codeword. Protocol errors are flagged. The parity word is handed to the spare-area writer with a one-cycle valid pulse.

## Interface
- T, 4, correctable bits; ECC_BITS = T*15 = 60
- DATA_BITS, 4288, data bits per codeword; must be a multiple of BITS
- BITS, 8, beat width; DATA_BEATS = DATA_BITS/BITS (536), ECC_BEATS = ceil(ECC_BITS/BITS) (8), PAD = ECC_BEATS*BITS - ECC_BITS (4)

- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  beat qualifier; inputs are sampled only when ce=1
- data_in  in  BITS  encoder data_out beat
- first  in  1  first beat of codeword
- last  in  1  final beat of codeword (last ECC beat)
- data_bits  in  1  beat is a data beat
- ecc_bits  in  1  beat is an ECC beat
- err_clr  in  1  clears protocol_err
- dout  out  BITS  forwarded data beat
- dout_valid  out  1  dout holds a data beat
- dout_first  out  1  dout is data beat 0
- dout_last  out  1  dout is data beat DATA_BEATS-1
- ecc_out  out  ECC_BEATS*BITS  packed parity; first ECC beat in the MSBs
- ecc_valid  out  1  one-cycle pulse: ecc_out updated
- protocol_err  out  1  sticky framing-error flag

## Operation
- States: IDLE, DATA, ECC. The state, counters and outputs change only on cycles where ce=1, except ecc_valid deassert and err_clr.
- IDLE: a beat with first=1 and data_bits=1 captures beat 0, sets dcnt=1 and enters DATA. Any other qualified beat is ignored, except that an ecc_bits beat sets protocol_err.
- DATA: each data_bits beat increments dcnt and is forwarded. When dcnt reaches DATA_BEATS, the state goes to ECC with ecnt=0.
- ECC: each ecc_bits beat shifts into the parity shift register, MSB-first, and increments ecnt. The beat with ecnt=ECC_BEATS-1 must carry last=1. On that beat:
  - ecc_out is loaded with the assembled word.
  - The low PAD bits of the final beat are forced to 1.
  - ecc_valid pulses and the state returns to IDLE.
- Errors set protocol_err, abort the frame without ecc_valid, and go to IDLE:
  - a data beat in ECC
  - an ECC beat in DATA
  - last=1 before the final ECC beat, or last missing on the final ECC beat
  - data_bits and ecc_bits both set
- first=1 in DATA or ECC sets protocol_err. It then restarts as beat 0 of a new frame in DATA.
- If err_clr and a new error occur in the same cycle, the error wins and protocol_err stays 1.
- Counter widths: dcnt is clog2(DATA_BEATS+1) bits, ecnt is clog2(ECC_BEATS+1) bits. Neither counter wraps; each resets at frame start.

## Timing
- Reset values:
  - state = IDLE
  - dout = 0, dout_valid = 0, dout_first = 0, dout_last = 0
  - ecc_out = 0, ecc_valid = 0
  - protocol_err = 0
- Data latency is 1 cycle: a data beat sampled at edge N appears on dout/dout_valid after edge N. dout_valid=0 in every cycle without a qualified data beat.
- ecc_valid is high for exactly the one clock after the final ECC beat's edge. It does not depend on ce that cycle.
- ecc_out holds stable until the next ecc_valid. It does not change on an aborted frame.
- No backpressure: the block always accepts beats.
- Asserting reset mid-frame discards the partial frame immediately; no ecc_valid follows.

## Configuration
- NUC970_PARITY_INVERT_EN defined: the ecc_out load is bitwise inverted, so a blank page reads as 0xFF parity. Padding is applied after the inversion, so PAD bits are still 1.
- NUC970_PARITY_INVERT_EN undefined: ecc_out is the raw assembled parity with PAD bits forced to 1.

## Test plan
- Good frame (macro off): 536 data beats 0x00..0xFF repeating, then 8 ECC beats 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xE0 with last on the 8th beat.
  - ecc_out = 0x123456789ABCDEEF; one ecc_valid pulse.
  - 536 dout_valid cycles; dout_first on 0x00, dout_last on beat 535.
- Same frame with NUC970_PARITY_INVERT_EN defined -> ecc_out = 0xEDCBA98765432110 | 0xF = 0xEDCBA9876543211F.
- Same frame with ce toggled 1/0 every cycle -> identical ecc_out; dout_valid only in cycles following ce=1 data beats.
- ECC beat at dcnt=100 -> protocol_err=1, no ecc_valid, state IDLE.
  - The next good frame still yields a correct ecc_out.
  - err_clr then clears the flag.
- last=1 on the 5th ECC beat -> protocol_err=1; ecc_out keeps its previous value.
- Reset asserted at ECC beat 3 -> all outputs 0 at once. A full frame after release produces exactly one ecc_valid.
